// File: rtl/radix2_div_sequencer_pkg.sv
// Shared definitions for the radix-2 divider sequencer: state encoding,
// divide-by-zero quotient, step count and the operand magnitude helper.
package radix2_div_sequencer_pkg;

    typedef enum logic [1:0] {
        L_PARAM_DIV_IDLE = 2'd0,
        L_PARAM_DIV_CALC = 2'd1,
        L_PARAM_DIV_FIX  = 2'd2,
        L_PARAM_DIV_OUT  = 2'd3
    } div_state_t;

    localparam logic [31:0] L_PARAM_DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
    localparam int          L_PARAM_DIV_STEPS         = 16;

    // 0x80000000 maps onto itself, which reads correctly as 2^31 unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        if (is_signed && value[31]) begin
            return 32'd0 - value;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/radix2_linediv.sv
// One radix-2 line-divider stage: consumes two dividend bits MSB-first and
// produces two quotient bits plus the updated 31-bit partial remainder.
module radix2_linediv (
    input  logic [1:0]  dividend_bits,
    input  logic [30:0] divisor,
    input  logic [30:0] rem_in,
    output logic [1:0]  quotient_bits,
    output logic [30:0] rem_out
);

    // Restoring step; since rem < divisor < 2^31 the shifted value fits 32 bits.
    function automatic logic [31:0] div_step(input logic [30:0] rem, input logic bit_in,
                                             input logic [30:0] dvs);
        logic [31:0] t;
        t = {rem, bit_in};
        if (t >= {1'b0, dvs}) begin
            return {1'b1, 31'(t - {1'b0, dvs})};
        end else begin
            return {1'b0, t[30:0]};
        end
    endfunction

    logic [31:0] step_hi_s;
    logic [31:0] step_lo_s;

    // Two chained subtract-or-keep steps, high dividend bit first.
    always_comb begin
        step_hi_s     = div_step(rem_in, dividend_bits[1], divisor);
        step_lo_s     = div_step(step_hi_s[30:0], dividend_bits[0], divisor);
        quotient_bits = {step_hi_s[31], step_lo_s[31]};
        rem_out       = step_lo_s[30:0];
    end

endmodule

// File: rtl/radix2_div_sequencer.sv
// Multi-cycle 32-bit integer divider controller for the execute stage.
// Optional data-dependent early termination: define RADIX2_DIV_EARLY_TERMINATE_EN.
module radix2_div_sequencer
    import radix2_div_sequencer_pkg::*;
#(
    parameter int P_LINEDIV_PER_CYCLE = 1
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iREMOVE,
    input  logic        iREQ_VALID,
    output logic        oREQ_BUSY,
    input  logic        iREQ_SIGNED,
    input  logic [31:0] iREQ_DIVIDEND,
    input  logic [31:0] iREQ_DIVISOR,
    output logic        oOUT_VALID,
    output logic [31:0] oOUT_QUOTIENT,
    output logic [31:0] oOUT_REMAINDER,
    output logic        oOUT_DIV_ZERO
);

    localparam int         L_BITS     = 2 * P_LINEDIV_PER_CYCLE;
    localparam logic [3:0] L_CYC_LAST = 4'(L_PARAM_DIV_STEPS / P_LINEDIV_PER_CYCLE - 1);

    div_state_t  state_r, state_s;
    logic [31:0] dd_r, quo_r, rem_r;
    logic [30:0] dvs_r;
    logic [3:0]  cnt_r;
    logic        qsign_r, rsign_r, div_zero_r;
    logic        busy_r, out_valid_r, out_div_zero_r;
    logic [31:0] out_quotient_r, out_remainder_r;

    logic        accept_s, divisor_zero_s, bypass_s, bypass_ge_s, early_zero_s;
    logic [31:0] dividend_mag_s, divisor_mag_s, dd_start_s;
    logic [3:0]  cnt_start_s;
    logic [L_BITS-1:0] q_chain_s;
    logic [30:0] r_final_s;

    assign accept_s       = iREQ_VALID && (state_r == L_PARAM_DIV_IDLE) && !iREMOVE;
    assign dividend_mag_s = magnitude(iREQ_DIVIDEND, iREQ_SIGNED);
    assign divisor_mag_s  = magnitude(iREQ_DIVISOR, iREQ_SIGNED);
    assign divisor_zero_s = (iREQ_DIVISOR == 32'd0);
    // The linediv remainder path is 31 bits, so divisors >= 2^31 resolve in one compare.
    assign bypass_s       = divisor_mag_s[31];
    assign bypass_ge_s    = (dividend_mag_s >= divisor_mag_s);

`ifdef RADIX2_DIV_EARLY_TERMINATE_EN
    function automatic logic [4:0] lz_pairs(input logic [31:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!hit && (v[2*i+1 -: 2] == 2'b00)) begin
                n = n + 5'd1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    logic [4:0] steps_up_s, skip_s;

    // Skip leading zero pairs, keeping whole cycles of P stages each.
    always_comb begin
        steps_up_s   = ((5'd16 - lz_pairs(dividend_mag_s)) + 5'(P_LINEDIV_PER_CYCLE - 1))
                       & ~5'(P_LINEDIV_PER_CYCLE - 1);
        skip_s       = 5'd16 - steps_up_s;
        early_zero_s = (steps_up_s == 5'd0);
        cnt_start_s  = 4'(skip_s >> $clog2(P_LINEDIV_PER_CYCLE));
        dd_start_s   = dividend_mag_s << {skip_s, 1'b0};
    end
`else
    assign early_zero_s = 1'b0;
    assign cnt_start_s  = 4'd0;
    assign dd_start_s   = dividend_mag_s;
`endif

    for (genvar g = 0; g < P_LINEDIV_PER_CYCLE; g++) begin : g_stage
        logic [30:0] rem_in_s;
        logic [30:0] rem_out_s;
        if (g == 0) begin : g_first
            assign rem_in_s = rem_r[30:0];
        end else begin : g_next
            assign rem_in_s = g_stage[g-1].rem_out_s;
        end
        if (g == P_LINEDIV_PER_CYCLE - 1) begin : g_last
            assign r_final_s = rem_out_s;
        end
        radix2_linediv u_linediv (
            .dividend_bits (dd_r[31-2*g -: 2]),
            .divisor       (dvs_r),
            .rem_in        (rem_in_s),
            .quotient_bits (q_chain_s[L_BITS-1-2*g -: 2]),
            .rem_out       (rem_out_s)
        );
    end

    // State register.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_r <= L_PARAM_DIV_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a flush returns to IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        if (iREMOVE) begin
            state_s = L_PARAM_DIV_IDLE;
        end else begin
            case (state_r)
                L_PARAM_DIV_IDLE: begin
                    if (accept_s) begin
                        if (divisor_zero_s || bypass_s || early_zero_s) begin
                            state_s = L_PARAM_DIV_FIX;
                        end else begin
                            state_s = L_PARAM_DIV_CALC;
                        end
                    end else begin
                        state_s = L_PARAM_DIV_IDLE;
                    end
                end
                L_PARAM_DIV_CALC: begin
                    if (cnt_r == L_CYC_LAST) begin
                        state_s = L_PARAM_DIV_FIX;
                    end else begin
                        state_s = L_PARAM_DIV_CALC;
                    end
                end
                L_PARAM_DIV_FIX: state_s = L_PARAM_DIV_OUT;
                L_PARAM_DIV_OUT: state_s = L_PARAM_DIV_IDLE;
                default:         state_s = L_PARAM_DIV_IDLE;
            endcase
        end
    end

    // Operand, remainder, quotient and result registers.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            dd_r            <= 32'd0;
            dvs_r           <= 31'd0;
            quo_r           <= 32'd0;
            rem_r           <= 32'd0;
            cnt_r           <= 4'd0;
            qsign_r         <= 1'b0;
            rsign_r         <= 1'b0;
            div_zero_r      <= 1'b0;
            busy_r          <= 1'b0;
            out_valid_r     <= 1'b0;
            out_quotient_r  <= 32'd0;
            out_remainder_r <= 32'd0;
            out_div_zero_r  <= 1'b0;
        end else begin
            busy_r      <= (state_s != L_PARAM_DIV_IDLE);
            out_valid_r <= (state_s == L_PARAM_DIV_OUT);
            if (iREMOVE) begin
                cnt_r <= 4'd0;
            end else if (accept_s) begin
                dd_r       <= dd_start_s;
                dvs_r      <= divisor_mag_s[30:0];
                cnt_r      <= cnt_start_s;
                qsign_r    <= iREQ_SIGNED & (iREQ_DIVIDEND[31] ^ iREQ_DIVISOR[31]);
                rsign_r    <= iREQ_SIGNED & iREQ_DIVIDEND[31];
                div_zero_r <= divisor_zero_s;
                if (divisor_zero_s) begin
                    quo_r   <= L_PARAM_DIV_ZERO_QUOTIENT;
                    rem_r   <= iREQ_DIVIDEND;
                    qsign_r <= 1'b0;
                    rsign_r <= 1'b0;
                end else if (bypass_s) begin
                    quo_r <= {31'd0, bypass_ge_s};
                    rem_r <= bypass_ge_s ? (dividend_mag_s - divisor_mag_s) : dividend_mag_s;
                end else begin
                    quo_r <= 32'd0;
                    rem_r <= 32'd0;
                end
            end else if (state_r == L_PARAM_DIV_CALC) begin
                dd_r  <= {dd_r[31-L_BITS:0], {L_BITS{1'b0}}};
                quo_r <= {quo_r[31-L_BITS:0], q_chain_s};
                rem_r <= {1'b0, r_final_s};
                cnt_r <= cnt_r + 4'd1;
            end else if (state_r == L_PARAM_DIV_FIX) begin
                out_quotient_r  <= qsign_r ? (32'd0 - quo_r) : quo_r;
                out_remainder_r <= rsign_r ? (32'd0 - rem_r) : rem_r;
                out_div_zero_r  <= div_zero_r;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign oREQ_BUSY      = busy_r;
    assign oOUT_VALID     = out_valid_r;
    assign oOUT_QUOTIENT  = out_quotient_r;
    assign oOUT_REMAINDER = out_remainder_r;
    assign oOUT_DIV_ZERO  = out_div_zero_r;

endmodule

// File: tb/tb_radix2_div_sequencer.sv
// Self-checking bench for radix2_div_sequencer: directed cases plus random
// operands on P=1/2/4 instances against a plain-arithmetic reference model.
module tb_radix2_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        remove = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_dividend = 32'd0;
    logic [31:0] req_divisor = 32'd0;
    logic        req_valid [3];
    logic        req_busy  [3];
    logic        out_valid [3];
    logic [31:0] out_q     [3];
    logic [31:0] out_r     [3];
    logic        out_dz    [3];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int lat;

    always #5 clk = ~clk;

    radix2_div_sequencer #(.P_LINEDIV_PER_CYCLE(1)) u_dut_p1 (
        .iCLOCK(clk), .iRESET(rst), .iREMOVE(remove), .iREQ_VALID(req_valid[0]),
        .oREQ_BUSY(req_busy[0]), .iREQ_SIGNED(req_signed), .iREQ_DIVIDEND(req_dividend),
        .iREQ_DIVISOR(req_divisor), .oOUT_VALID(out_valid[0]), .oOUT_QUOTIENT(out_q[0]),
        .oOUT_REMAINDER(out_r[0]), .oOUT_DIV_ZERO(out_dz[0]));

    radix2_div_sequencer #(.P_LINEDIV_PER_CYCLE(2)) u_dut_p2 (
        .iCLOCK(clk), .iRESET(rst), .iREMOVE(remove), .iREQ_VALID(req_valid[1]),
        .oREQ_BUSY(req_busy[1]), .iREQ_SIGNED(req_signed), .iREQ_DIVIDEND(req_dividend),
        .iREQ_DIVISOR(req_divisor), .oOUT_VALID(out_valid[1]), .oOUT_QUOTIENT(out_q[1]),
        .oOUT_REMAINDER(out_r[1]), .oOUT_DIV_ZERO(out_dz[1]));

    radix2_div_sequencer #(.P_LINEDIV_PER_CYCLE(4)) u_dut_p4 (
        .iCLOCK(clk), .iRESET(rst), .iREMOVE(remove), .iREQ_VALID(req_valid[2]),
        .oREQ_BUSY(req_busy[2]), .iREQ_SIGNED(req_signed), .iREQ_DIVIDEND(req_dividend),
        .iREQ_DIVISOR(req_divisor), .oOUT_VALID(out_valid[2]), .oOUT_QUOTIENT(out_q[2]),
        .oOUT_REMAINDER(out_r[2]), .oOUT_DIV_ZERO(out_dz[2]));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Truncating division in 64-bit arithmetic; -2^31/-1 wraps naturally.
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, q64, r64;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else begin
            sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q64 = sa / sb;
            r64 = sa % sb;
            q = q64[31:0]; r = r64[31:0]; dz = 1'b0;
        end
    endtask

    function automatic int lat_model(input int p, input logic sgn, input logic [31:0] a,
                                     input logic [31:0] b);
        logic [31:0] mb;
`ifdef RADIX2_DIV_EARLY_TERMINATE_EN
        logic [31:0] ma;
        int bits, pairs;
`endif
        mb = mag(b, sgn);
        if (b == 32'd0 || mb[31]) return 2;
`ifdef RADIX2_DIV_EARLY_TERMINATE_EN
        ma = mag(a, sgn);
        if (ma == 32'd0) return 2;
        bits = 0;
        for (int i = 0; i < 32; i++) if (ma[i]) bits = i + 1;
        pairs = (bits + 1) / 2;
        return (pairs + p - 1) / p + 2;
`else
        return 16 / p + 2;
`endif
    endfunction

    // Issue one request on instance idx and check latency, busy and result.
    task automatic run_div(input int idx, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input string tag, output int n);
        logic [31:0] eq, er;
        logic        edz;
        logic        busy_ok;
        int          elat;
        ref_div(sgn, a, b, eq, er, edz);
        elat = lat_model(1 << idx, sgn, a, b);
        @(negedge clk);
        check_value({tag, "_idle"}, {31'd0, req_busy[idx]}, 32'd0);
        req_signed = sgn; req_dividend = a; req_divisor = b; req_valid[idx] = 1'b1;
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!out_valid[idx] && n < 64) begin
            if (!req_busy[idx]) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!req_busy[idx]) busy_ok = 1'b0;
        check_value({tag, "_lat"}, n, elat);
        check_value({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check_value({tag, "_q"}, out_q[idx], eq);
        check_value({tag, "_r"}, out_r[idx], er);
        check_value({tag, "_dz"}, {31'd0, out_dz[idx]}, {31'd0, edz});
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;

        #2;
        for (int i = 0; i < 3; i++) begin
            check_value("rst_busy", {31'd0, req_busy[i]}, 32'd0);
            check_value("rst_valid", {31'd0, out_valid[i]}, 32'd0);
            check_value("rst_q", out_q[i], 32'd0);
            check_value("rst_r", out_r[i], 32'd0);
            check_value("rst_dz", {31'd0, out_dz[i]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div(0, 1'b0, 32'd100, 32'd7, "u100_7", lat);
        check_value("u100_7_q_const", out_q[0], 32'd14);
        check_value("u100_7_r_const", out_r[0], 32'd2);
        run_div(0, 1'b1, 32'hFFFF_FFF9, 32'd2, "sm7_2", lat);
        check_value("sm7_2_q_const", out_q[0], 32'hFFFF_FFFD);
        check_value("sm7_2_r_const", out_r[0], 32'hFFFF_FFFF);
        run_div(0, 1'b1, 32'd7, 32'hFFFF_FFFE, "s7_m2", lat);
        run_div(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf", lat);
        check_value("s_ovf_q_const", out_q[0], 32'h8000_0000);
        run_div(0, 1'b0, 32'h0000_1234, 32'd0, "dz", lat);
        check_value("dz_lat_const", lat, 32'd2);
        run_div(0, 1'b1, 32'hFFFF_FFF0, 32'd0, "dz_signed", lat);
        run_div(0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, "bypass", lat);
        check_value("bypass_r_const", out_r[0], 32'h7FFF_FFFE);
        run_div(1, 1'b1, 32'hFFFF_FFFB, 32'h8000_0000, "bypass_s", lat);

        // A flush in IDLE wins over a simultaneous request.
        @(negedge clk);
        req_signed = 1'b0; req_dividend = 32'd50; req_divisor = 32'd5;
        req_valid[0] = 1'b1; remove = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0; remove = 1'b0;
        check_value("rm_prio_busy", {31'd0, req_busy[0]}, 32'd0);

        // Flush at CALC cycle 5, then issue the next request right away.
        @(negedge clk);
        req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd3; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 remove = 1'b1;
        check_value("rm_valid", {31'd0, out_valid[0]}, 32'd0);
        @(posedge clk);
        #1 remove = 1'b0;
        check_value("rm_busy_fell", {31'd0, req_busy[0]}, 32'd0);
        run_div(0, 1'b0, 32'd9, 32'd3, "rm_next", lat);

        // Asynchronous reset between edges mid-CALC.
        @(negedge clk);
        req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd3; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_value("arst_busy", {31'd0, req_busy[0]}, 32'd0);
        check_value("arst_valid", {31'd0, out_valid[0]}, 32'd0);
        check_value("arst_q", out_q[0], 32'd0);
        check_value("arst_r", out_r[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef RADIX2_DIV_EARLY_TERMINATE_EN
        run_div(0, 1'b0, 32'd3, 32'd1, "early3_1", lat);
        check_value("early_lat_lt18", {31'd0, (lat < 18)}, 32'd1);
        run_div(2, 1'b0, 32'd0, 32'd9, "early0", lat);
`endif

        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 300; n++) begin
                sgn = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0:       a = 32'h8000_0000;
                    1:       a = 32'($urandom_range(0, 3));
                    default: a = $urandom >> $urandom_range(0, 31);
                endcase
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1:       b = $urandom | 32'h8000_0000;
                    2:       b = 32'($urandom_range(1, 15));
                    3:       b = 32'hFFFF_FFFF;
                    default: b = $urandom >> $urandom_range(0, 31);
                endcase
                run_div(idx, sgn, a, b, "rnd", lat);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
